// File: rtl/issue_queue.sv
// Multi-lane in-order issue queue: a circular buffer of {instr, pc} entries
// that accepts up to LANES pushes and LANES issues per cycle, zero-latency read.
module issue_queue #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8,
  parameter int LANES = 2,
  parameter int CW    = $clog2(LANES + 1)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic [CW-1:0]              in_cnt,
  input  logic [LANES*WIDTH-1:0]     in_data,
  input  logic [WIDTH-1:0]           in_pc,
  output logic                       in_ready,
  output logic [LANES*WIDTH-1:0]     out_data,
  output logic [LANES*WIDTH-1:0]     out_pc,
  output logic [LANES-1:0]           out_valid,
  input  logic [CW-1:0]              out_take,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int NW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_instr [DEPTH];
  logic [WIDTH-1:0] r_pc    [DEPTH];
  logic [AW-1:0]    r_head;
  logic [AW-1:0]    r_tail;
  logic [NW-1:0]    r_count;

  logic [NW-1:0]    w_free;
  logic             w_ready;
  logic [NW-1:0]    w_cnt_clip;
  logic [NW-1:0]    w_push_amt;
  logic [NW-1:0]    w_take;
  logic [NW-1:0]    w_pop_amt;

  // Admission uses pre-edge occupancy only, so a same-cycle pop never makes room.
  assign w_free     = NW'(DEPTH) - r_count;
  assign w_ready    = (w_free >= NW'(LANES));
  assign w_cnt_clip = (in_cnt > CW'(LANES)) ? NW'(LANES) : NW'(in_cnt);
  assign w_push_amt = (w_ready && !flush) ? w_cnt_clip : '0;
  assign w_take     = NW'(out_take);
  assign w_pop_amt  = flush ? '0 : ((w_take > r_count) ? r_count : w_take);

  assign in_ready = w_ready;
  assign count    = r_count;
  assign full     = (r_count == NW'(DEPTH));
  assign empty    = (r_count == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_head  <= r_head + w_pop_amt[AW-1:0];
      r_tail  <= r_tail + w_push_amt[AW-1:0];
      r_count <= r_count + w_push_amt - w_pop_amt;
    end
  end

  // Storage is not reset; unoccupied entries are masked on the read side.
  always_ff @(posedge clk) begin
    for (int i = 0; i < LANES; i++) begin
      if (NW'(i) < w_push_amt) begin
        r_instr[r_tail + AW'(i)] <= in_data[i*WIDTH +: WIDTH];
        r_pc[r_tail + AW'(i)]    <= in_pc + WIDTH'(4 * i);
      end
    end
  end

  always_comb begin
    out_data  = '0;
    out_pc    = '0;
    out_valid = '0;
    for (int i = 0; i < LANES; i++) begin
      if (r_count > NW'(i)) begin
        out_valid[i]               = 1'b1;
        out_data[i*WIDTH +: WIDTH] = r_instr[r_head + AW'(i)];
        out_pc[i*WIDTH +: WIDTH]   = r_pc[r_head + AW'(i)];
      end
    end
  end

endmodule

// File: tb/tb_issue_queue.sv
// Bench for issue_queue: directed scenarios plus random traffic, all checked
// against a queue-based reference model of the buffer contents.
module tb_issue_queue;
  localparam int W  = 32;
  localparam int D  = 8;
  localparam int L  = 2;
  localparam int CW = 2;
  localparam int NW = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            flush;
  logic [CW-1:0]   in_cnt;
  logic [L*W-1:0]  in_data;
  logic [W-1:0]    in_pc;
  logic            in_ready;
  logic [L*W-1:0]  out_data;
  logic [L*W-1:0]  out_pc;
  logic [L-1:0]    out_valid;
  logic [CW-1:0]   out_take;
  logic [NW-1:0]   count;
  logic            full;
  logic            empty;

  issue_queue #(.WIDTH(W), .DEPTH(D), .LANES(L), .CW(CW)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_cnt(in_cnt), .in_data(in_data), .in_pc(in_pc), .in_ready(in_ready),
    .out_data(out_data), .out_pc(out_pc), .out_valid(out_valid),
    .out_take(out_take), .count(count), .full(full), .empty(empty)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  logic [W-1:0] q_data[$];
  logic [W-1:0] q_pc[$];

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_outputs(input string ctx);
    logic [L*W-1:0] e_data;
    logic [L*W-1:0] e_pc;
    logic [L-1:0]   e_valid;
    int sz;
    sz = q_data.size();
    e_data = '0; e_pc = '0; e_valid = '0;
    for (int i = 0; i < L; i++) begin
      if (i < sz) begin
        e_valid[i]       = 1'b1;
        e_data[i*W +: W] = q_data[i];
        e_pc[i*W +: W]   = q_pc[i];
      end
    end
    chk({ctx, ".count"}, 128'(count), 128'(sz));
    chk({ctx, ".ready"}, 128'(in_ready), 128'((D - sz) >= L));
    chk({ctx, ".full"},  128'(full), 128'(sz == D));
    chk({ctx, ".empty"}, 128'(empty), 128'(sz == 0));
    chk({ctx, ".valid"}, 128'(out_valid), 128'(e_valid));
    chk({ctx, ".data"},  128'(out_data), 128'(e_data));
    chk({ctx, ".pc"},    128'(out_pc), 128'(e_pc));
  endtask

  // Reference: what the queue holds after the coming edge given current inputs.
  task automatic model_edge();
    int sz, pop, n;
    bit rdy;
    if (flush) begin
      q_data.delete(); q_pc.delete();
      return;
    end
    sz  = q_data.size();
    pop = (int'(out_take) < sz) ? int'(out_take) : sz;
    rdy = (D - sz) >= L;
    n   = (int'(in_cnt) > L) ? L : int'(in_cnt);
    for (int i = 0; i < pop; i++) begin
      void'(q_data.pop_front()); void'(q_pc.pop_front());
    end
    if (rdy) begin
      for (int i = 0; i < n; i++) begin
        q_data.push_back(in_data[i*W +: W]);
        q_pc.push_back(in_pc + W'(4 * i));
      end
    end
  endtask

  task automatic cycle(input string ctx);
    model_edge();
    @(posedge clk);
    #1;
    check_outputs(ctx);
  endtask

  task automatic drive(input int c, input int t, input logic [W-1:0] d0,
                       input logic [W-1:0] d1, input logic [W-1:0] pc);
    in_cnt   = CW'(c);
    out_take = CW'(t);
    in_data  = {d1, d0};
    in_pc    = pc;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0;
    drive(0, 0, '0, '0, '0);
    #12;
    check_outputs("reset");
    @(negedge clk);
    rst = 1'b0;

    // First push becomes visible one edge later.
    drive(2, 0, 32'hA, 32'hB, 32'h100);
    cycle("push1");
    chk("p1.lane0", 128'(out_data[31:0]), 128'h0A);
    chk("p1.lane1", 128'(out_data[63:32]), 128'h0B);
    chk("p1.pc0",   128'(out_pc[31:0]), 128'h100);
    chk("p1.pc1",   128'(out_pc[63:32]), 128'h104);

    flush = 1'b1; drive(0, 0, '0, '0, '0);
    cycle("flush0");
    flush = 1'b0;

    // Fill to full, then an ignored push.
    for (int k = 0; k < 5; k++) begin
      drive(2, 0, W'(16 + 2*k), W'(17 + 2*k), W'(32'h200 + 8*k));
      cycle("fill");
      if (k == 2) chk("fill.cnt6", 128'(count), 128'd6);
    end
    chk("full.cnt",   128'(count), 128'd8);
    chk("full.flag",  128'(full), 128'd1);
    chk("full.ready", 128'(in_ready), 128'd0);

    drive(0, 1, '0, '0, '0);
    cycle("to7");
    drive(2, 2, 32'hDEAD, 32'hBEEF, 32'h900);
    cycle("rej");
    chk("rej.cnt5", 128'(count), 128'd5);

    drive(0, 2, '0, '0, '0);
    cycle("drain"); cycle("drain");
    cycle("clip");
    chk("clip.cnt",   128'(count), 128'd0);
    chk("clip.empty", 128'(empty), 128'd1);
    chk("clip.valid", 128'(out_valid), 128'd0);

    drive(2, 0, 32'h1, 32'h2, 32'h300); cycle("f5");
    drive(3, 0, 32'h3, 32'h4, 32'h308); cycle("f5");
    drive(1, 0, 32'h5, 32'h6, 32'h310); cycle("f5");
    chk("f5.cnt", 128'(count), 128'd5);
    flush = 1'b1; drive(2, 1, 32'h7, 32'h8, 32'h400);
    cycle("flushx");
    flush = 1'b0;
    chk("flushx.cnt", 128'(count), 128'd0);

    // Asynchronous reset pulse between edges.
    drive(2, 0, 32'h11, 32'h22, 32'h500);
    cycle("prerst");
    drive(0, 0, '0, '0, '0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    q_data.delete(); q_pc.delete();
    check_outputs("arst");
    #1;
    rst = 1'b0;

    // Random traffic, wrapping head and tail many times.
    for (int k = 0; k < 400; k++) begin
      flush = ($urandom_range(0, 31) == 0);
      drive(int'($urandom_range(0, 3)), int'($urandom_range(0, 2)),
            $urandom, $urandom, {$urandom, 2'b00});
      cycle("rand");
    end
    flush = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/issue_queue.md
ISSUE_QUEUE -- requirements
Module: issue_queue

Interface
REQ-001 Parameter WIDTH, default 32, instruction and PC word width in bits.
REQ-002 Parameter DEPTH, default 8, queue entries; SHALL be a power of two and >= 2*LANES.
REQ-003 Parameter LANES, default 2, maximum instructions pushed or issued per cycle.
REQ-004 Parameter CW, default $clog2(LANES+1), width of lane-count fields.
REQ-005 clk  input  1  single clock; all state changes on rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-high.
REQ-007 flush  input  1  discard all queued entries (branch or restart).
REQ-008 in_cnt  input  CW  number of valid lanes in in_data, lane 0 first; 0 = no push.
REQ-009 in_data  input  LANES*WIDTH  fetched bundle; lane i in bits [i*WIDTH +: WIDTH].
REQ-010 in_pc  input  WIDTH  PC of lane 0; lane i PC = in_pc + 4*i.
REQ-011 in_ready  output  1  high when free entries >= LANES.
REQ-012 out_data  output  LANES*WIDTH  oldest LANES entries, lane 0 = head.
REQ-013 out_pc  output  LANES*WIDTH  PCs matching out_data lanes.
REQ-014 out_valid  output  LANES  thermometer; bit i high when count > i.
REQ-015 out_take  input  CW  number of head entries consumed this cycle.
REQ-016 count  output  $clog2(DEPTH+1)  current occupancy.
REQ-017 full, empty  output  1 each  count == DEPTH, count == 0.

Function
REQ-018 Storage SHALL be a circular buffer of DEPTH {instr, pc} entries with head and tail pointers wrapping modulo DEPTH.
REQ-019 Push SHALL occur when in_cnt > 0 and in_ready is high; lanes 0..in_cnt-1 written at tail, tail += in_cnt.
REQ-020 When in_ready is low, in_cnt SHALL be ignored; no entry written, no pointer change.
REQ-021 in_cnt > LANES SHALL be treated as LANES.
REQ-022 Pop amount SHALL be min(out_take, count) using pre-edge count; head += pop amount.
REQ-023 in_ready SHALL be computed from pre-edge count only; same-cycle pop does not create push space.
REQ-024 Simultaneous push and pop SHALL yield count_next = count + push_amt - pop_amt.
REQ-025 out_data, out_pc, out_valid SHALL be combinational from head and count (zero-latency read); invalid lanes drive 0.
REQ-026 Entries written at edge N SHALL be visible on outputs after edge N (one-cycle push-to-issue latency).
REQ-027 Lane reads SHALL wrap: lane i reads entry (head + i) mod DEPTH.
REQ-028 flush high at an edge SHALL set head = tail = 0, count = 0 and ignore that cycle's push and pop.
REQ-029 Pointer and count arithmetic SHALL never underflow or exceed DEPTH.

Reset
REQ-030 rst high SHALL immediately, without waiting for clk, set head = 0, tail = 0, count = 0.
REQ-031 During reset: empty = 1, full = 0, in_ready = 1, out_valid = 0, out_data = 0, out_pc = 0.
REQ-032 Storage array contents need not be cleared; outputs SHALL be masked by out_valid.
REQ-033 rst asserted mid-operation SHALL discard all entries; first push after deassertion lands at entry 0.

Verification (WIDTH=32, DEPTH=8, LANES=2)
REQ-034 Reset then push in_cnt=2, data {0xB,0xA}, in_pc=0x100 -> next cycle count=2, out_valid=2'b11, lane0=0xA/0x100, lane1=0xB/0x104.
REQ-035 Push 2 per cycle with out_take=0 for 3 cycles -> count=6, in_ready=1; fourth push -> count=8, full=1, in_ready=0; fifth push ignored, count stays 8.
REQ-036 count=7, in_cnt=2, out_take=2 -> push rejected (in_ready=0), count_next=5.
REQ-037 count=1, out_take=2 -> pop clipped to 1, count=0, empty=1, out_valid=0.
REQ-038 Fill/drain 20 entries with pushes of 1 and 2 and takes of 0..2 -> issue order and PCs match push order across head/tail wrap, no loss or duplication.
REQ-039 count=5, flush with in_cnt=2 and out_take=1 -> next cycle count=0, empty=1; async rst pulse between edges -> outputs reset before next clk edge.
